// File: rtl/seq_scan_pkg.sv
// Shared types and default sizes for the word-fed sequence scan controller.
package seq_scan_pkg;

    localparam int unsigned DEF_WORD_W = 8;
    localparam int unsigned DEF_PAT_W  = 4;
    localparam int unsigned DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int unsigned pat_len_w(input int unsigned pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_pat_match.sv
// Bit-serial pattern matcher: history shift register, fill counter and masked compare.
module seq_pat_match
    import seq_scan_pkg::*;
#(
    parameter int unsigned  PAT_W     = DEF_PAT_W,
    localparam int unsigned PAT_LEN_W = pat_len_w(PAT_W)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 bit_in,
    input  logic                 bit_en,
    input  logic                 clr,
    input  logic [PAT_W-1:0]     pat,
    input  logic [PAT_LEN_W-1:0] pat_len,
    input  logic                 overlap_en,
    output logic                 match
);

    logic [PAT_W-1:0]     hist_q, hist_d, hist_shift, mask;
    logic [PAT_LEN_W-1:0] fill_q, fill_d, fill_inc;
    logic                 len_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    // Match is judged on the history including the bit arriving this cycle.
    always_comb begin
        hist_shift = PAT_W'({hist_q, bit_in});
        fill_inc   = (fill_q == PAT_LEN_W'(PAT_W)) ? fill_q : fill_q + PAT_LEN_W'(1);
        mask       = (PAT_W'(1) << pat_len) - PAT_W'(1);
        len_ok     = (pat_len != '0) && (pat_len <= PAT_LEN_W'(PAT_W));
        match      = bit_en && len_ok && (fill_inc >= pat_len)
                     && (((hist_shift ^ pat) & mask) == '0);
        hist_d     = hist_q;
        fill_d     = fill_q;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (bit_en) begin
            hist_d = hist_shift;
            fill_d = (match && !overlap_en) ? '0 : fill_inc;
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-fed scan controller: feeds words MSB-first into seq_pat_match, counts matches, raises irq.
// Optional SEQ_SCAN_CTRL_ABORT_EN adds an abort input that ends a scan early.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int unsigned  WORD_W    = DEF_WORD_W,
    parameter int unsigned  PAT_W     = DEF_PAT_W,
    parameter int unsigned  CNT_W     = DEF_CNT_W,
    localparam int unsigned PAT_LEN_W = pat_len_w(PAT_W)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [PAT_W-1:0]     pat,
    input  logic [PAT_LEN_W-1:0] pat_len,
    input  logic                 overlap_en,
    input  logic [CNT_W-1:0]     threshold,
    input  logic                 irq_clr,
`ifdef SEQ_SCAN_CTRL_ABORT_EN
    input  logic                 abort,
`endif
    input  logic                 in_valid,
    input  logic [WORD_W-1:0]    in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 busy,
    output logic                 match_pulse,
    output logic [CNT_W-1:0]     match_count,
    output logic                 irq,
    output logic                 done
);

    localparam int unsigned BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    state_t               state_q, state_d;
    logic [WORD_W-1:0]    word_q, word_d;
    logic                 last_q, last_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [PAT_W-1:0]     pat_q, pat_d;
    logic [PAT_LEN_W-1:0] len_q, len_d;
    logic                 ovl_q, ovl_d;
    logic [CNT_W-1:0]     thr_q, thr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic                 irq_q, irq_d, irq_set;
    logic                 pulse_q, pulse_d;
    logic                 bit_en, clr, match;

    seq_pat_match #(.PAT_W(PAT_W)) u_match (
        .clk        (clk),
        .reset_n    (reset_n),
        .bit_in     (word_q[WORD_W-1]),
        .bit_en     (bit_en),
        .clr        (clr),
        .pat        (pat_q),
        .pat_len    (len_q),
        .overlap_en (ovl_q),
        .match      (match)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            word_q    <= '0;
            last_q    <= 1'b0;
            bit_cnt_q <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            ovl_q     <= 1'b0;
            thr_q     <= '0;
            cnt_q     <= '0;
            irq_q     <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            last_q    <= last_d;
            bit_cnt_q <= bit_cnt_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            thr_q     <= thr_d;
            cnt_q     <= cnt_d;
            irq_q     <= irq_d;
            pulse_q   <= pulse_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        last_d    = last_q;
        bit_cnt_d = bit_cnt_q;
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        thr_d     = thr_q;
        cnt_d     = cnt_q;
        irq_d     = irq_q;
        pulse_d   = 1'b0;
        irq_set   = 1'b0;
        bit_en    = 1'b0;
        clr       = 1'b0;
        cnt_inc   = cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d   = pat;
                    len_d   = pat_len;
                    ovl_d   = overlap_en;
                    thr_d   = threshold;
                    cnt_d   = '0;
                    irq_d   = 1'b0;
                    clr     = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    word_d    = in_data;
                    last_d    = in_last;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                bit_en    = 1'b1;
                word_d    = word_q << 1;
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                if (bit_cnt_q == BIT_W'(WORD_W - 1)) begin
                    state_d = last_q ? DONE : LOAD;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

`ifdef SEQ_SCAN_CTRL_ABORT_EN
        if (abort && ((state_q == LOAD) || (state_q == SHIFT))) begin
            state_d = DONE;
        end
`endif

        // Count saturates; irq fires only on the transition onto a non-zero threshold.
        if (match) begin
            pulse_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d   = cnt_inc;
                irq_set = (cnt_inc == thr_q) && (thr_q != '0);
            end
        end
        if (irq_clr) irq_d = 1'b0;
        if (irq_set) irq_d = 1'b1;
    end

    assign in_ready    = (state_q == LOAD);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign match_pulse = pulse_q;
    assign match_count = cnt_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl: reference model predicts pulse/done cycles, counts and irq.
module tb_seq_scan_ctrl;

    localparam int WW = 8;
    localparam int PW = 4;
    localparam int CW = 8;
    localparam int LW = 3;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        int cyc;
        int cnt;
        bit irq;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [PW-1:0] pat = '0;
    logic [LW-1:0] pat_len = '0;
    logic          overlap_en = 1'b0;
    logic [CW-1:0] threshold = '0;
    logic          irq_clr = 1'b0;
    logic          in_valid = 1'b0;
    logic [WW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          in_ready, busy, match_pulse, irq, done;
    logic [CW-1:0] match_count;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t mq[$];
    exp_t dq[$];
    exp_t me, md;

    // reference model state
    bit       mbits[$];
    logic [PW-1:0] mpat;
    int       mlen, mthr, mcnt, since;
    bit       movl, mirq;
    logic [WW-1:0] wbuf[$];

    seq_scan_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .pat         (pat),
        .pat_len     (pat_len),
        .overlap_en  (overlap_en),
        .threshold   (threshold),
        .irq_clr     (irq_clr),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .busy        (busy),
        .match_pulse (match_pulse),
        .match_count (match_count),
        .irq         (irq),
        .done        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint got, input longint expv);
        n_tests++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, expv, cyc);
        end
    endtask

    // Monitor: every pulse/done must match the head of its queue, and no expected event may be skipped.
    always @(negedge clk) begin
        if (match_pulse) begin
            if (mq.size() == 0) chk("pulse_unexpected", match_pulse, 0);
            else begin
                me = mq.pop_front();
                chk("pulse_cyc", cyc, me.cyc);
                chk("pulse_cnt", match_count, me.cnt);
                chk("pulse_irq", irq, me.irq);
            end
        end else if (mq.size() > 0 && mq[0].cyc <= cyc) begin
            me = mq.pop_front();
            chk("pulse_missing", match_pulse, 1);
        end
        if (done) begin
            if (dq.size() == 0) chk("done_unexpected", done, 0);
            else begin
                md = dq.pop_front();
                chk("done_cyc", cyc, md.cyc);
                chk("done_cnt", match_count, md.cnt);
                chk("done_irq", irq, md.irq);
            end
        end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
            md = dq.pop_front();
            chk("done_missing", done, 1);
        end
    end

    // Predict matches of one word whose handshake happens at posedge number h.
    task automatic model_word(input logic [WW-1:0] w, input bit last, input int h);
        bit   b, hit;
        exp_t e;
        for (int j = 0; j < WW; j++) begin
            b = w[WW-1-j];
            mbits.push_back(b);
            if (mbits.size() > PW) void'(mbits.pop_front());
            since++;
            hit = (mlen >= 1) && (mlen <= PW) && (since >= mlen);
            if (hit) begin
                for (int k = 0; k < mlen; k++) begin
                    if (mbits[mbits.size() - mlen + k] != mpat[mlen-1-k]) hit = 1'b0;
                end
            end
            if (hit) begin
                if (!movl) since = 0;
                if (mcnt < CMAX) begin
                    mcnt++;
                    if (mcnt == mthr && mthr != 0) mirq = 1'b1;
                end
                e.cyc = h + j + 1;
                e.cnt = mcnt;
                e.irq = mirq;
                mq.push_back(e);
            end
        end
        if (last) begin
            e.cyc = h + WW;
            e.cnt = mcnt;
            e.irq = mirq;
            dq.push_back(e);
        end
    endtask

    task automatic begin_scan(input logic [PW-1:0] p, input int len, input bit ovl, input int thr);
        int k = 0;
        @(negedge clk);
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (busy) chk("idle_timeout", busy, 0);
        start = 1'b1;
        pat = p;
        pat_len = LW'(len);
        overlap_en = ovl;
        threshold = CW'(thr);
        mpat = p; mlen = len; movl = ovl; mthr = thr;
        mbits.delete();
        since = 0; mcnt = 0; mirq = 1'b0;
        @(negedge clk);
        start = 1'b0;
        pat = PW'($urandom);
        pat_len = LW'($urandom);
        overlap_en = 1'($urandom);
        threshold = CW'($urandom);
    endtask

    task automatic send_word(input logic [WW-1:0] w, input bit last, input int gap);
        int k = 0;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("ready_timeout", in_ready, 1);
        for (int g = 0; g < gap; g++) begin
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
            start = 1'b0;
            chk("gap_ready", in_ready, 1);
        end
        in_valid = 1'b1;
        in_data = w;
        in_last = last;
        model_word(w, last, cyc + 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data = WW'($urandom);
        in_last = 1'($urandom);
    endtask

    task automatic finish_scan();
        int k = 0;
        while ((busy || mq.size() > 0 || dq.size() > 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (busy) chk("scan_timeout", busy, 0);
        mq.delete();
        dq.delete();
    endtask

    task automatic run_scan(input logic [PW-1:0] p, input int len, input bit ovl, input int thr,
                            input int maxgap);
        begin_scan(p, len, ovl, thr);
        for (int i = 0; i < wbuf.size(); i++) begin
            send_word(wbuf[i], (i == wbuf.size() - 1), $urandom_range(0, maxgap));
        end
        finish_scan();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulse", match_pulse, 0);
        chk("rst_count", match_count, 0);
        chk("rst_irq", irq, 0);
        chk("rst_done", done, 0);
        reset_n = 1'b1;

        // overlapping matches in one word
        wbuf = '{8'b1011_0110};
        run_scan(4'b1011, 4, 1'b1, 0, 0);
        chk("tp_ovl_count", match_count, 2);

        // non-overlapping
        wbuf = '{8'b1011_0110};
        run_scan(4'b1011, 4, 1'b0, 0, 0);
        chk("tp_novl_count", match_count, 1);

        // match spanning a word boundary, with idle gap
        begin_scan(4'b1011, 4, 1'b1, 0);
        send_word(8'b0000_0010, 1'b0, 0);
        send_word(8'b1100_0000, 1'b1, 3);
        finish_scan();
        chk("tp_span_count", match_count, 1);

        // threshold irq then clear
        wbuf = '{8'b1011_0110};
        run_scan(4'b1011, 4, 1'b1, 2, 0);
        chk("tp_irq_set", irq, 1);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        chk("tp_irq_clr", irq, 0);
        chk("tp_irq_cnt_hold", match_count, 2);

        // saturation: 256 single-bit matches into an 8-bit counter
        wbuf.delete();
        repeat (32) wbuf.push_back(8'hFF);
        run_scan(4'b0001, 1, 1'b1, CMAX, 0);
        chk("tp_sat_count", match_count, CMAX);
        chk("tp_sat_irq", irq, 1);

        // illegal lengths: scan completes with no matches
        wbuf = '{8'hFF, 8'h00};
        run_scan(4'b1111, 0, 1'b1, 1, 1);
        chk("tp_len0_count", match_count, 0);
        wbuf = '{8'hFF, 8'hFF};
        run_scan(4'b1111, 5, 1'b1, 1, 1);
        chk("tp_len5_count", match_count, 0);

        // reset mid-SHIFT aborts immediately
        begin_scan(4'b0001, 1, 1'b1, 0);
        send_word(8'hFF, 1'b1, 0);
        @(negedge clk);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        mq.delete();
        dq.delete();
        #1;
        chk("midrst_outs", {in_ready, busy, match_pulse, match_count, irq, done}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        wbuf = '{8'b1011_0110};
        run_scan(4'b1011, 4, 1'b1, 0, 0);
        chk("midrst_clean_count", match_count, 2);

        // randomized scans
        repeat (40) begin
            len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(1, 4));
            wbuf.delete();
            repeat ($urandom_range(1, 4)) wbuf.push_back(WW'($urandom));
            run_scan(PW'($urandom), len, 1'($urandom_range(0, 1)), int'($urandom_range(0, 6)), 3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
